audio_event_sched: RTL and testbench

//  Parametrised sound-event scheduler between game logic and the PWM audio player.
//  - Edge-detects NUM_EVENTS request lines and queues them as pending bits.
//  - Arbitrates by fixed priority; index 0 is the highest.
//  - Drives the player select/enable handshake, with optional preemption,
//    a watchdog timeout and sticky "terminal" events (dead/win) that latch silence.

---
 rtl/audio_event_sched.sv | 106 ++++++++++
 tb/tb_audio_event_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/audio_event_sched.sv
// audio_event_sched: fixed-priority sound-event scheduler driving the PWM player handshake,
// with preemption, a saturating watchdog and sticky terminal events that latch silence.
module audio_event_sched #(
   parameter int                    NUM_EVENTS   = 4,
   parameter int                    SEL_W        = $clog2(NUM_EVENTS + 1),
   parameter logic [NUM_EVENTS-1:0] STICKY_MASK  = NUM_EVENTS'(4'b0110),
   parameter logic [NUM_EVENTS-1:0] PREEMPT_MASK = NUM_EVENTS'(4'b0110),
   parameter int                    TIMEOUT_CYC  = 50_000_000
) (
   input  logic                  Clk,
   input  logic                  reset_rtl_0,
   input  logic [NUM_EVENTS-1:0] ev_req,
   input  logic                  player_done,
   input  logic                  hold_clr,
   output logic                  play_en,
   output logic [SEL_W-1:0]      play_sel,
   output logic                  play_start,
   output logic [NUM_EVENTS-1:0] pending,
   output logic                  busy,
   output logic                  held,
   output logic                  timeout_err
);
   localparam int IDX_W = NUM_EVENTS > 1 ? $clog2(NUM_EVENTS) : 1;
   localparam int WD_W = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
   localparam bit WD_ON = TIMEOUT_CYC != 0;

   typedef enum logic [1:0] {IDLE, START, PLAY, HOLD} state_t;

   state_t                state, state_n;
   logic [NUM_EVENTS-1:0] prev, rise, clr, pending_n;
   logic [IDX_W-1:0]      cur, cur_n, win, pre;
   logic                  cur_valid, pre_any, done;
   logic [WD_W-1:0]       wd;

   assign rise        = ev_req & ~prev;
   assign timeout_err = WD_ON && state == PLAY && wd == WD_LAST;
   assign done        = state == PLAY && (player_done || timeout_err);
   assign play_en     = cur_valid;
   assign play_sel    = cur_valid ? SEL_W'(cur) + SEL_W'(1) : '0;
   assign play_start  = state == START;
   assign busy        = state == START || state == PLAY;
   assign held        = state == HOLD;

   // Descending scan so the lowest pending index wins.
   always_comb begin
      win = '0;
      pre = '0;
      pre_any = 1'b0;
      for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
         if (pending[i]) win = IDX_W'(i);
         if (pending[i] && PREEMPT_MASK[i] && IDX_W'(i) < cur) begin
            pre = IDX_W'(i);
            pre_any = 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      cur_n = cur;
      clr = '0;
      case (state)
         IDLE: if (|pending) begin
            state_n = START;
            cur_n = win;
            clr = NUM_EVENTS'(1) << win;
         end
         START: state_n = PLAY;
         PLAY: if (done) begin
            if (STICKY_MASK[cur]) state_n = HOLD;
            else if (|pending) begin
               state_n = START;
               cur_n = win;
               clr = NUM_EVENTS'(1) << win;
            end else state_n = IDLE;
         end else if (pre_any) begin
            state_n = START;
            cur_n = pre;
            clr = NUM_EVENTS'(1) << pre;
         end
         default: if (hold_clr) state_n = IDLE;
      endcase
   end

   // Rise set beats grant clear; anything touching HOLD keeps the queue empty.
   assign pending_n = (state == HOLD || state_n == HOLD) ? '0 : (pending & ~clr) | rise;

   always_ff @(posedge Clk) begin
      if (!reset_rtl_0) begin
         state     <= IDLE;
         cur       <= '0;
         cur_valid <= 1'b0;
         pending   <= '0;
         prev      <= '1;
         wd        <= '0;
      end else begin
         state     <= state_n;
         cur       <= cur_n;
         cur_valid <= state_n == START || state_n == PLAY;
         pending   <= pending_n;
         prev      <= ev_req;
         wd        <= state == START ? '0 : (state == PLAY && wd != '1) ? wd + 1'b1 : wd;
      end
   end
endmodule

// File: tb/tb_audio_event_sched.sv
// tb_audio_event_sched: directed bench for audio_event_sched; a queue scoreboard checks
// every play_start against the clip expected when the stimulus was driven.
module tb_audio_event_sched;
   logic       Clk = 1'b0;
   logic       reset_rtl_0, player_done, hold_clr;
   logic [3:0] ev_req;
   logic       play_en, play_start, busy, held, timeout_err;
   logic [2:0] play_sel;
   logic [3:0] pending;
   int         compared = 0;
   int         mismatched = 0;
   int         exp_q[$];
   int         cnt, n;

   audio_event_sched #(.NUM_EVENTS(4), .STICKY_MASK(4'b0110), .PREEMPT_MASK(4'b0110),
                       .TIMEOUT_CYC(100)) dut (
      .Clk(Clk), .reset_rtl_0(reset_rtl_0), .ev_req(ev_req), .player_done(player_done),
      .hold_clr(hold_clr), .play_en(play_en), .play_sel(play_sel), .play_start(play_start),
      .pending(pending), .busy(busy), .held(held), .timeout_err(timeout_err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Scoreboard: every clip start must match the oldest expected selection.
   always @(posedge Clk) begin
      #1;
      if (reset_rtl_0 === 1'b1 && play_start === 1'b1) begin
         if (exp_q.size() == 0) chk("sb_unexpected_start", exp_q.size(), 1);
         else chk("sb_sel", play_sel, exp_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      reset_rtl_0 = 1'b0; ev_req = '0; player_done = 1'b0; hold_clr = 1'b0;
      tick(); tick();
      chk("rst_play_en", play_en, 0);
      chk("rst_play_sel", play_sel, 0);
      chk("rst_pending", pending, 0);
      chk("rst_busy_held", {busy, held, play_start, timeout_err}, 0);
      reset_rtl_0 = 1'b1;
      tick();
      // 1: single low-priority event, done after 20 PLAY cycles
      ev_req = 4'b1000; exp_q.push_back(4);
      tick();
      chk("t1_pending_latency", pending, 4'b1000);
      ev_req = '0;
      tick();
      chk("t1_start", play_start, 1);
      cnt = (play_sel == 3'd4) ? 1 : 0;
      repeat (20) begin
         tick();
         if (play_sel == 3'd4) cnt++;
      end
      player_done = 1'b1;
      tick();
      player_done = 1'b0;
      chk("t1_sel_cycles", cnt, 21);
      chk("t1_idle_sel", play_sel, 0);
      chk("t1_idle_en_busy", {play_en, busy}, 0);
      // 2: simultaneous rises, index 0 first
      ev_req = 4'b1001; exp_q.push_back(1); exp_q.push_back(4);
      tick();
      chk("t2_pending_both", pending, 4'b1001);
      ev_req = '0;
      tick();
      chk("t2_pending_after_grant0", pending, 4'b1000);
      chk("t2_sel0", play_sel, 1);
      repeat (3) tick();
      player_done = 1'b1;
      tick();
      player_done = 1'b0;
      chk("t2_restart", play_start, 1);
      chk("t2_sel3", play_sel, 4);
      chk("t2_pending_empty", pending, 0);
      // 3: preemption by sticky event 1, then HOLD
      tick(); tick();
      ev_req = 4'b0010; exp_q.push_back(2);
      tick(); tick();
      chk("t3_preempt_start", play_start, 1);
      chk("t3_preempt_sel", play_sel, 2);
      chk("t3_pending_dropped", pending, 0);
      ev_req = '0;
      repeat (3) tick();
      player_done = 1'b1;
      tick();
      player_done = 1'b0;
      chk("t3_held", held, 1);
      chk("t3_hold_silent", {play_en, play_sel, busy}, 0);
      ev_req = 4'b0001;
      tick(); tick();
      chk("t3_hold_ignores_rise", pending, 0);
      chk("t3_still_held", held, 1);
      ev_req = '0;
      hold_clr = 1'b1;
      tick();
      hold_clr = 1'b0;
      chk("t3_hold_clr", {held, busy}, 0);
      tick();
      chk("t3_no_grant_after_hold", {busy, pending}, 0);
      // 4: watchdog on event 0, hold_clr ignored in PLAY
      ev_req = 4'b0001; exp_q.push_back(1);
      tick();
      ev_req = '0;
      tick();
      chk("t4_start", play_start, 1);
      n = 0;
      for (int i = 1; i <= 150; i++) begin
         hold_clr = (i == 10);
         tick();
         if (timeout_err) begin
            n = i;
            break;
         end
      end
      hold_clr = 1'b0;
      chk("t4_timeout_cycle", n, 100);
      chk("t4_play_en_at_timeout", play_en, 1);
      tick();
      chk("t4_pulse_len", timeout_err, 0);
      chk("t4_idle", {busy, play_sel}, 0);
      // 5: level held through reset does not fire
      reset_rtl_0 = 1'b0; ev_req = 4'b0100;
      tick(); tick();
      reset_rtl_0 = 1'b1;
      repeat (4) tick();
      chk("t5_no_grant", {busy, pending}, 0);
      ev_req = '0;
      tick();
      ev_req = 4'b0100; exp_q.push_back(3);
      tick();
      chk("t5_pending", pending, 4'b0100);
      tick();
      chk("t5_start", {play_start, play_sel}, {1'b1, 3'd3});
      // 6: reset mid-play
      repeat (3) tick();
      chk("t6_playing", busy, 1);
      reset_rtl_0 = 1'b0;
      tick();
      reset_rtl_0 = 1'b1;
      chk("t6_outputs_zero", {play_en, play_sel, play_start, busy, held, timeout_err}, 0);
      chk("t6_pending_zero", pending, 0);
      repeat (3) tick();
      chk("t6_stays_idle", {busy, pending}, 0);
      chk("sb_leftover", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
